// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } arb_state_e;

   // Wide enough for the largest legal TIMEOUT (65535)
   localparam int unsigned CNT_W = 16;

   function automatic int unsigned strb_width(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter view, master = environment view.
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned STRB_W = strb_width(DATA_W);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [STRB_W-1:0] d_wstrb;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;

   logic              mem_valid;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [STRB_W-1:0] mem_wstrb;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   logic              stall_req;
   logic              err;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ready,
      output if_rdata, if_ack, d_rdata, d_ack,
      output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, stall_req, err
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ready,
      input  if_rdata, if_ack, d_rdata, d_ack,
      input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, stall_req, err
   );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter; expired_c flags the enabled cycle whose increment reaches TIMEOUT.
module mem_timeout_ctr
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired_c
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign expired_c = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, with data-priority
// arbitration that yields to fetch after a data grant, plus a per-transaction timeout.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_port_arbiter_if.slave    bus
);

   localparam int unsigned STRB_W = strb_width(DATA_W);

   arb_state_e        state_q;
   logic              last_d_q;
   logic              mem_valid_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [STRB_W-1:0] mem_wstrb_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              if_ack_q;
   logic              d_ack_q;
   logic              err_q;

   logic i_pend_c, d_pend_c, gnt_c, wait_c, expired_c;

   // A requester being acked this cycle is still holding req; it must not re-win.
   assign i_pend_c = bus.if_req & ~if_ack_q;
   assign d_pend_c = bus.d_req  & ~d_ack_q;
   assign gnt_c    = (state_q != IDLE);
   assign wait_c   = gnt_c & ~bus.mem_ready;

   mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .clear     (~gnt_c),
      .enable    (wait_c),
      .expired_c (expired_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         last_d_q    <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_ack_q    <= 1'b0;
         d_ack_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if_ack_q <= 1'b0;
         d_ack_q  <= 1'b0;
         err_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (d_pend_c && (!i_pend_c || !last_d_q)) begin
                  state_q     <= GNT_D;
                  mem_valid_q <= 1'b1;
                  mem_we_q    <= bus.d_we;
                  mem_addr_q  <= bus.d_addr;
                  mem_wdata_q <= bus.d_wdata;
                  mem_wstrb_q <= bus.d_wstrb;
               end else if (i_pend_c) begin
                  state_q     <= GNT_I;
                  mem_valid_q <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= bus.if_addr;
                  mem_wdata_q <= '0;
                  mem_wstrb_q <= '0;
               end
            end
            GNT_I, GNT_D: begin
               // Completion by ready takes precedence over a timeout on the same edge
               if (bus.mem_ready || expired_c) begin
                  state_q     <= IDLE;
                  mem_valid_q <= 1'b0;
                  err_q       <= ~bus.mem_ready;
                  if (state_q == GNT_D) begin
                     d_ack_q   <= 1'b1;
                     last_d_q  <= 1'b1;
                     d_rdata_q <= (bus.mem_ready && !mem_we_q) ? bus.mem_rdata : '0;
                  end else begin
                     if_ack_q   <= 1'b1;
                     last_d_q   <= 1'b0;
                     if_rdata_q <= bus.mem_ready ? bus.mem_rdata : '0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mem_valid = mem_valid_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_wstrb = mem_wstrb_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.if_ack    = if_ack_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.err       = err_q;
   assign bus.stall_req = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (instantiated with TIMEOUT=4).
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.if_req = 0; bus.if_addr = '0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
      bus.mem_rdata = '0; bus.mem_ready = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      tick();
      n_checks++; if (bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid got %b want 0", bus.mem_valid); end
      n_checks++; if ({bus.if_ack, bus.d_ack, bus.err} !== 3'b000) begin n_fail++; $display("FAIL reset_acks got %b want 000", {bus.if_ack, bus.d_ack, bus.err}); end
      n_checks++; if ({bus.if_rdata, bus.d_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", {bus.if_rdata, bus.d_rdata}); end
      n_checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 69'h0) begin n_fail++; $display("FAIL reset_mem_bus got %h want 0", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}); end
      rst = 0;
      tick();
   endtask

   task automatic test_fetch();
      bus.if_req = 1; bus.if_addr = 32'h100;
      #1;
      n_checks++; if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_n got %b want 1", bus.stall_req); end
      tick();
      n_checks++; if ({bus.mem_valid, bus.mem_we, bus.mem_wstrb} !== 6'b100000) begin n_fail++; $display("FAIL fetch_grant got %b want 100000", {bus.mem_valid, bus.mem_we, bus.mem_wstrb}); end
      n_checks++; if (bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL fetch_addr got %h want 100", bus.mem_addr); end
      n_checks++; if ({bus.stall_req, bus.if_ack} !== 2'b10) begin n_fail++; $display("FAIL fetch_stall_n1 got %b want 10", {bus.stall_req, bus.if_ack}); end
      bus.mem_ready = 1; bus.mem_rdata = 32'h13;
      tick();
      n_checks++; if ({bus.if_ack, bus.d_ack, bus.err, bus.mem_valid, bus.stall_req} !== 5'b10000) begin n_fail++; $display("FAIL fetch_ack got %b want 10000", {bus.if_ack, bus.d_ack, bus.err, bus.mem_valid, bus.stall_req}); end
      n_checks++; if (bus.if_rdata !== 32'h13) begin n_fail++; $display("FAIL fetch_rdata got %h want 13", bus.if_rdata); end
      bus.if_req = 0; bus.mem_ready = 0; bus.mem_rdata = 32'hFFFF_FFFF;
      tick();
      n_checks++; if ({bus.if_ack, bus.mem_valid} !== 2'b00) begin n_fail++; $display("FAIL fetch_single_pulse got %b want 00", {bus.if_ack, bus.mem_valid}); end
      n_checks++; if (bus.if_rdata !== 32'h13) begin n_fail++; $display("FAIL fetch_rdata_hold got %h want 13", bus.if_rdata); end
   endtask

   task automatic test_both_pending();
      bus.if_req = 1; bus.if_addr = 32'h104;
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'hF;
      tick();
      n_checks++; if ({bus.mem_valid, bus.mem_we, bus.mem_wstrb} !== 6'b111111) begin n_fail++; $display("FAIL both_d_grant got %b want 111111", {bus.mem_valid, bus.mem_we, bus.mem_wstrb}); end
      n_checks++; if ({bus.mem_addr, bus.mem_wdata} !== 64'h0000_0200_DEAD_BEEF) begin n_fail++; $display("FAIL both_d_bus got %h want 00000200deadbeef", {bus.mem_addr, bus.mem_wdata}); end
      bus.mem_ready = 1; bus.mem_rdata = 32'h55;
      tick();
      n_checks++; if ({bus.d_ack, bus.if_ack, bus.err} !== 3'b100) begin n_fail++; $display("FAIL both_d_ack got %b want 100", {bus.d_ack, bus.if_ack, bus.err}); end
      n_checks++; if (bus.d_rdata !== 32'h0) begin n_fail++; $display("FAIL both_write_rdata got %h want 0", bus.d_rdata); end
      bus.d_req = 0; bus.d_we = 0;
      tick();
      n_checks++; if ({bus.mem_valid, bus.mem_we, bus.d_ack, bus.if_ack} !== 4'b1000) begin n_fail++; $display("FAIL both_i_grant got %b want 1000", {bus.mem_valid, bus.mem_we, bus.d_ack, bus.if_ack}); end
      n_checks++; if (bus.mem_addr !== 32'h104) begin n_fail++; $display("FAIL both_i_addr got %h want 104", bus.mem_addr); end
      tick();
      n_checks++; if ({bus.if_ack, bus.d_ack} !== 2'b10) begin n_fail++; $display("FAIL both_i_ack got %b want 10", {bus.if_ack, bus.d_ack}); end
      n_checks++; if (bus.if_rdata !== 32'h55) begin n_fail++; $display("FAIL both_i_rdata got %h want 55", bus.if_rdata); end
      bus.if_req = 0; bus.mem_ready = 0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_addr;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
      bus.if_req = 1; bus.if_addr = 32'h108;
      bus.mem_ready = 1; bus.mem_rdata = 32'h77;
      for (int k = 0; k < 4; k++) begin
         exp_addr = (k % 2 == 0) ? 32'h300 : 32'h108;
         tick();
         n_checks++; if ({bus.mem_valid, bus.mem_addr} !== {1'b1, exp_addr}) begin n_fail++; $display("FAIL alt_grant_%0d got %h want %h", k, {bus.mem_valid, bus.mem_addr}, {1'b1, exp_addr}); end
         tick();
         n_checks++; if ({bus.d_ack, bus.if_ack} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL alt_ack_%0d got %b want %b", k, {bus.d_ack, bus.if_ack}, (k % 2 == 0) ? 2'b10 : 2'b01); end
      end
      n_checks++; if (bus.d_rdata !== 32'h77) begin n_fail++; $display("FAIL alt_d_rdata got %h want 77", bus.d_rdata); end
      bus.d_req = 0; bus.if_req = 0; bus.mem_ready = 0;
      tick();
   endtask

   task automatic test_timeout();
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h400; bus.mem_ready = 0;
      tick();
      n_checks++; if (bus.mem_valid !== 1'b1) begin n_fail++; $display("FAIL to_grant got %b want 1", bus.mem_valid); end
      for (int c = 1; c < 4; c++) begin
         tick();
         n_checks++; if ({bus.mem_valid, bus.d_ack, bus.err} !== 3'b100) begin n_fail++; $display("FAIL to_wait_%0d got %b want 100", c, {bus.mem_valid, bus.d_ack, bus.err}); end
      end
      tick();
      n_checks++; if ({bus.mem_valid, bus.d_ack, bus.err} !== 3'b011) begin n_fail++; $display("FAIL to_abort got %b want 011", {bus.mem_valid, bus.d_ack, bus.err}); end
      n_checks++; if (bus.d_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata got %h want 0", bus.d_rdata); end
      bus.d_req = 0;
      tick();
      n_checks++; if ({bus.mem_valid, bus.d_ack, bus.err} !== 3'b000) begin n_fail++; $display("FAIL to_after got %b want 000", {bus.mem_valid, bus.d_ack, bus.err}); end
   endtask

   task automatic test_reset_mid_grant();
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500; bus.mem_ready = 0;
      tick();
      n_checks++; if (bus.mem_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_grant got %b want 1", bus.mem_valid); end
      #1 rst = 1;
      #1;
      n_checks++; if ({bus.mem_valid, bus.d_ack, bus.mem_addr} !== 33'h0) begin n_fail++; $display("FAIL rst_mid_async got %h want 0", {bus.mem_valid, bus.d_ack, bus.mem_addr}); end
      bus.d_req = 0;
      tick();
      n_checks++; if ({bus.d_ack, bus.if_ack, bus.if_rdata} !== 34'h0) begin n_fail++; $display("FAIL rst_mid_noack got %h want 0", {bus.d_ack, bus.if_ack, bus.if_rdata}); end
      rst = 0;
      tick();
      bus.if_req = 1; bus.if_addr = 32'h600; bus.mem_ready = 1; bus.mem_rdata = 32'h99;
      tick();
      n_checks++; if ({bus.mem_valid, bus.mem_addr} !== 33'h1_0000_0600) begin n_fail++; $display("FAIL rst_regrant got %h want 100000600", {bus.mem_valid, bus.mem_addr}); end
      tick();
      n_checks++; if ({bus.if_ack, bus.if_rdata} !== 33'h1_0000_0099) begin n_fail++; $display("FAIL rst_reack got %h want 100000099", {bus.if_ack, bus.if_rdata}); end
      bus.if_req = 0; bus.mem_ready = 0;
      tick();
   endtask

   task automatic test_idle_ready();
      bus.mem_ready = 1; bus.mem_rdata = 32'hABCD;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++; if ({bus.mem_valid, bus.if_ack, bus.d_ack, bus.err} !== 4'b0000) begin n_fail++; $display("FAIL idle_ready_%0d got %b want 0000", c, {bus.mem_valid, bus.if_ack, bus.d_ack, bus.err}); end
      end
      n_checks++; if (bus.if_rdata !== 32'h99) begin n_fail++; $display("FAIL idle_rdata_hold got %h want 99", bus.if_rdata); end
      bus.mem_ready = 0;
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_both_pending();
      test_back_to_back();
      test_timeout();
      test_reset_mid_grant();
      test_idle_ready();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width.
REQ-002 Parameter: DATA_W, 32, data width; strobe width is DATA_W/8.
REQ-003 Parameter: TIMEOUT, 255, maximum wait cycles for mem_ready before abort; legal range 1 to 65535.
REQ-004 Port: clk  in  1  clock; all state changes on the rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Ports: if_req in 1 fetch request; if_addr in ADDR_W; if_rdata out DATA_W; if_ack out 1 completion pulse.
REQ-007 Ports: d_req in 1 data request; d_we in 1 write; d_addr in ADDR_W; d_wdata in DATA_W; d_wstrb in DATA_W/8; d_rdata out DATA_W; d_ack out 1.
REQ-008 Ports: mem_valid, mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_wstrb out DATA_W/8; mem_rdata in DATA_W; mem_ready in 1.
REQ-009 Ports: stall_req out 1 pipeline stall request; err out 1 timeout flag, valid with ack.

Function
REQ-010 The block SHALL share one memory port between fetch and data, using FSM states IDLE, GNT_I and GNT_D.
REQ-011 Requester handshake: req, addr, we, wdata and wstrb held stable from req rise until the ack cycle; the block SHALL NOT depend on values after ack.
REQ-012 In IDLE at a clock edge: d_req only -> GNT_D; if_req only -> GNT_I; neither -> IDLE.
REQ-013 Both pending in IDLE: d_req wins, unless the previous completed grant was data, in which case if_req wins (no back-to-back data starvation of fetch).
REQ-014 On entering a GNT state, the block SHALL register the winner's address, we, wdata and wstrb onto mem_*; for fetch, mem_we=0 and mem_wstrb=0.
REQ-015 mem_valid SHALL be 1 in GNT_I/GNT_D and 0 in IDLE; mem_* SHALL stay constant while mem_valid=1.
REQ-016 Edge with mem_ready=1 in GNT_x: capture mem_rdata into x_rdata (0 for writes), pulse x_ack=1 for exactly one cycle, err=0, return to IDLE.
REQ-017 Minimum latency: req sampled at edge N, mem_valid high N+1, with mem_ready=1 then ack high N+2.
REQ-018 In the cycle x_ack=1, the block SHALL ignore x_req for arbitration; the other requester may be granted at that edge.
REQ-019 x_rdata SHALL hold its value until the next ack to the same requester.
REQ-020 Wait counter SHALL clear on grant and increment each GNT cycle with mem_ready=0; if it reaches TIMEOUT: drop mem_valid, pulse x_ack with err=1, x_rdata=0, go to IDLE.
REQ-021 mem_ready when mem_valid=0 SHALL be ignored.
REQ-022 stall_req = (if_req and not if_ack) or (d_req and not d_ack), combinational.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, mem_valid=0, all acks=0, err=0, rdata=0, mem_* =0, counter=0, last-grant=fetch.
REQ-024 Reset during GNT SHALL abandon the transaction without an ack; the requester re-issues after reset.

Structure
REQ-025 State encoding (IDLE=0, GNT_I=1, GNT_D=2) and strobe-width constant SHALL reside in shared package mem_arb_pkg.
REQ-026 The wait counter SHALL be sub-module mem_timeout_ctr (clear, enable, expired output, TIMEOUT parameter).

Verification
REQ-027 if_req with if_addr=0x100 alone, mem_ready at first valid cycle, mem_rdata=0x13 -> if_ack at edge N+2, if_rdata=0x13, stall_req high during N..N+1.
REQ-028 if_req and d_req (write 0x200, 0xDEADBEEF, wstrb 0xF) together from IDLE, last grant=fetch -> data served first with mem_we=1, then fetch; two ack pulses, never overlapping.
REQ-029 d_req held continuously plus if_req -> grants alternate D, I, D, I.
REQ-030 mem_ready held 0 with TIMEOUT=4 -> d_ack=1 and err=1 after 4 GNT cycles, d_rdata=0, mem_valid low next cycle.
REQ-031 rst asserted mid-GNT_D -> mem_valid=0 without a clock edge, no d_ack; after release, fresh if_req granted normally.
REQ-032 mem_ready pulsed while idle -> no ack, no state change.
